md_unit: RTL and testbench

- Multiply/divide unit for the five-stage MIPS pipeline. Sits beside the ALU in the E stage.
- Consumes the forwarded E-stage rs/rt operands and holds the HI/LO architectural registers.
- Exposes `busy` so the D-stage hazard logic can stall later mult/div/mfhi/mflo/mthi/mtlo.
- mfhi/mflo read `hi`/`lo` directly in E through the existing result mux.

---
 rtl/md_unit_pkg.sv | 41 ++++
 rtl/md_unit_if.sv | 25 ++
 rtl/md_unit_arith.sv | 45 ++++
 rtl/md_unit.sv | 116 +++++++++++
 tb/tb_md_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// FSM states, default latencies and small decode helpers.
package md_unit_pkg;

  // Operation codes presented on md_op; 6 and 7 are reserved and do nothing.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } mdOp_t;

  // Controller states. The busy states carry a suffix so they do not collide
  // with the MD_DIV operation code above.
  typedef enum logic [1:0] {
    MD_IDLE     = 2'd0,
    MD_MUL_BUSY = 2'd1,
    MD_DIV_BUSY = 2'd2
  } mdState_t;

  localparam int MD_MULT_CYCLES_DEFAULT = 5;
  localparam int MD_DIV_CYCLES_DEFAULT  = 10;

  // True for the two's-complement flavours of mult/div.
  function automatic logic opIsSigned(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // True for either divide flavour.
  function automatic logic opIsDiv(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for either multiply flavour.
  function automatic logic opIsMul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
interface md_unit_if;
  import md_unit_pkg::*;

  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  // The pipeline drives operands and reads back HI/LO and the stall flag.
  modport master (
    output start, md_op, A, B,
    input  busy, hi, lo
  );

  // The md unit consumes operands and owns HI/LO.
  modport slave (
    input  start, md_op, A, B,
    output busy, hi, lo
  );

endinterface

// File: rtl/md_unit_arith.sv
// Combinational arithmetic core: signed/unsigned 32x32 multiply and divide.
// Result is packed as {hi, lo}: product for mult, {remainder, quotient} for div.
module md_arith
  import md_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        divZero
);

  logic        isSigned;
  logic        negA;
  logic        negB;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] divisor;
  logic [31:0] uQuot;
  logic [31:0] uRem;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] prodMag;
  logic [63:0] prod;

  // Work on magnitudes and fix signs afterwards, which gives truncation toward
  // zero, a dividend-signed remainder, and the 0x80000000 / -1 wrap for free.
  always_comb begin
    isSigned = opIsSigned(op);
    negA     = isSigned & a[31];
    negB     = isSigned & b[31];
    magA     = negA ? (~a + 32'd1) : a;
    magB     = negB ? (~b + 32'd1) : b;
    divZero  = (b == 32'd0);
    divisor  = divZero ? 32'd1 : magB;
    uQuot    = magA / divisor;
    uRem     = magA % divisor;
    quot     = (negA ^ negB) ? (~uQuot + 32'd1) : uQuot;
    rem      = negA ? (~uRem + 32'd1) : uRem;
    prodMag  = {32'd0, magA} * {32'd0, magB};
    prod     = (negA ^ negB) ? (~prodMag + 64'd1) : prodMag;
    result   = opIsDiv(op) ? {rem, quot} : prod;
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit beside the E-stage ALU. Owns HI/LO, computes the result
// when the operation is accepted, then holds it back for a fixed busy period
// so the hazard logic sees a multi-cycle unit.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEFAULT
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdState_t    state, stateNext;
  logic [CW-1:0] count, countNext;
  logic [31:0] hiReg, hiNext;
  logic [31:0] loReg, loNext;
  logic [31:0] pendingHi, pendingHiNext;
  logic [31:0] pendingLo, pendingLoNext;
  logic        pendingDivZero, pendingDivZeroNext;
  logic [63:0] arithResult;
  logic        arithDivZero;

  md_arith arith (
    .op      (md.md_op),
    .a       (md.A),
    .b       (md.B),
    .result  (arithResult),
    .divZero (arithDivZero)
  );

  assign md.busy = (state != MD_IDLE);
  assign md.hi   = hiReg;
  assign md.lo   = loReg;

  // Register all controller and architectural state; reset abandons any
  // in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= MD_IDLE;
      count          <= '0;
      hiReg          <= '0;
      loReg          <= '0;
      pendingHi      <= '0;
      pendingLo      <= '0;
      pendingDivZero <= 1'b0;
    end else begin
      state          <= stateNext;
      count          <= countNext;
      hiReg          <= hiNext;
      loReg          <= loNext;
      pendingHi      <= pendingHiNext;
      pendingLo      <= pendingLoNext;
      pendingDivZero <= pendingDivZeroNext;
    end
  end

  // Accept a new operation only when idle; while busy, count down and commit
  // the pending result on the last busy cycle (skipped for divide by zero).
  always_comb begin
    stateNext          = state;
    countNext          = count;
    hiNext             = hiReg;
    loNext             = loReg;
    pendingHiNext      = pendingHi;
    pendingLoNext      = pendingLo;
    pendingDivZeroNext = pendingDivZero;

    case (state)
      MD_IDLE: begin
        if (md.start) begin
          if (opIsMul(md.md_op)) begin
            pendingHiNext      = arithResult[63:32];
            pendingLoNext      = arithResult[31:0];
            pendingDivZeroNext = 1'b0;
            countNext          = CW'(MULT_CYCLES);
            stateNext          = MD_MUL_BUSY;
          end else if (opIsDiv(md.md_op)) begin
            pendingHiNext      = arithResult[63:32];
            pendingLoNext      = arithResult[31:0];
            pendingDivZeroNext = arithDivZero;
            countNext          = CW'(DIV_CYCLES);
            stateNext          = MD_DIV_BUSY;
          end else if (md.md_op == MD_MTHI) begin
            hiNext = md.A;
          end else if (md.md_op == MD_MTLO) begin
            loNext = md.A;
          end
        end
      end

      MD_MUL_BUSY, MD_DIV_BUSY: begin
        if (count == CW'(1)) begin
          if (!(state == MD_DIV_BUSY && pendingDivZero)) begin
            hiNext = pendingHi;
            loNext = pendingLo;
          end
          countNext = '0;
          stateNext = MD_IDLE;
        end else begin
          countNext = count - CW'(1);
        end
      end

      default: begin
        stateNext = MD_IDLE;
        countNext = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues the expected busy length and
// HI/LO for each long operation; the monitor checks them when busy drops.
module tb_md_unit;
  import md_unit_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } expect_t;

  logic    clk = 1'b0;
  logic    reset;
  expect_t expQ[$];
  int      testsRun = 0;
  int      failures = 0;

  bit          wasBusy = 1'b0;
  int          busyLen = 0;
  logic [31:0] holdHi;
  logic [31:0] holdLo;
  bit          holdOk;

  md_unit_if bus();

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  // 10-time-unit clock period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    testsRun++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
    end
  endtask

  // Pulse start for exactly one clock; operands are scrambled afterwards so
  // any failure to capture them at acceptance shows up in the result.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = 32'hDEADBEEF;
    bus.B     = 32'hCAFEF00D;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      testsRun++;
      failures++;
      $display("[TB] FAIL busy timeout: busy still %b after %0d cycles, required 0", bus.busy, n);
    end
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi,
                       input logic [31:0] expLo, input int len);
    expQ.push_back('{name: name, hi: expHi, lo: expLo, len: len});
    applyStimulus(op, a, b);
    waitIdle();
  endtask

  // Monitor: measures each busy period, checks HI/LO never move while busy,
  // and compares the committed values against the scoreboard on completion.
  initial begin : monitor
    expect_t e;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        if (!wasBusy) begin
          holdHi  = bus.hi;
          holdLo  = bus.lo;
          holdOk  = 1'b1;
          busyLen = 0;
        end else if (bus.hi !== holdHi || bus.lo !== holdLo) begin
          holdOk = 1'b0;
        end
        busyLen++;
        wasBusy = 1'b1;
      end else if (wasBusy) begin
        wasBusy = 1'b0;
        if (expQ.size() == 0) begin
          testsRun++;
          failures++;
          $display("[TB] FAIL unexpected completion: busy period of %0d cycles, required none", busyLen);
        end else begin
          e = expQ.pop_front();
          checkOutput({e.name, " busy cycles"}, 32'(busyLen), 32'(e.len));
          checkOutput({e.name, " hi"}, bus.hi, e.hi);
          checkOutput({e.name, " lo"}, bus.lo, e.lo);
          checkOutput({e.name, " hold while busy"}, {31'd0, holdOk}, 32'd1);
        end
      end
    end
  end

  // Backstop in case the stimulus itself stalls.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin : stimulus
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset hi", bus.hi, 32'd0);
    checkOutput("reset lo", bus.lo, 32'd0);

    runOp("mult -1*2",  MD_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    runOp("multu",      MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
    runOp("mult -3*4",  MD_MULT,  32'hFFFFFFFD, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF4, 5);
    runOp("div -7/2",   MD_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    runOp("div 7/-2",   MD_DIV,   32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);
    runOp("divu 7/2",   MD_DIVU,  32'd7, 32'd2, 32'h00000001, 32'h00000003, 10);
    runOp("div ovf",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);

    // mthi then mtlo on consecutive cycles; each lands on the next edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = MD_MTHI;
    bus.A     = 32'h12345678;
    @(negedge clk);
    checkOutput("mthi hi", bus.hi, 32'h12345678);
    checkOutput("mthi busy", {31'd0, bus.busy}, 32'd0);
    bus.md_op = MD_MTLO;
    bus.A     = 32'h9ABCDEF0;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("mtlo lo", bus.lo, 32'h9ABCDEF0);
    checkOutput("mtlo hi", bus.hi, 32'h12345678);
    checkOutput("mtlo busy", {31'd0, bus.busy}, 32'd0);

    // Divide by zero keeps HI/LO; starts issued while busy are ignored.
    expQ.push_back('{name: "divu by zero", hi: 32'h12345678, lo: 32'h9ABCDEF0, len: 10});
    applyStimulus(MD_DIVU, 32'd5, 32'd0);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = MD_MULT;
    bus.A     = 32'd3;
    bus.B     = 32'd4;
    @(negedge clk);
    bus.md_op = MD_MTHI;
    bus.A     = 32'hDEADBEEF;
    @(negedge clk);
    bus.start = 1'b0;
    waitIdle();

    // Reserved op code: no busy, no register change.
    applyStimulus(3'd6, 32'h55555555, 32'h66666666);
    checkOutput("reserved busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reserved hi", bus.hi, 32'h12345678);
    checkOutput("reserved lo", bus.lo, 32'h9ABCDEF0);

    // Reset during the third busy cycle of a mult aborts it.
    expQ.push_back('{name: "reset abort", hi: 32'd0, lo: 32'd0, len: 3});
    applyStimulus(MD_MULT, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort busy", {31'd0, bus.busy}, 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("no late write hi", bus.hi, 32'd0);
    checkOutput("no late write lo", bus.lo, 32'd0);

    runOp("mult after reset", MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);

    repeat (2) @(negedge clk);
    if (expQ.size() != 0) begin
      testsRun++;
      failures++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, required 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
